// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings and types for the memory request arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned MASK_W = 16;

    localparam logic [TYPE_W-1:0] CMD_READ  = 3'b001;
    localparam logic [TYPE_W-1:0] CMD_WRITE = 3'b010;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TYPE_W-1:0] typ;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA
    } state_t;

    function automatic logic is_read(input logic [TYPE_W-1:0] t);
        return t == CMD_READ;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and memory-controller-side channels of the arbiter.
interface mem_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ*32-1:0]  req_addr;
    logic [NUM_REQ*3-1:0]   req_type;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_wdata;
    logic [NUM_REQ*16-1:0]  req_wmask;
    logic [NUM_REQ-1:0]     req_wvalid;
    logic [NUM_REQ-1:0]     req_wready;
    logic [127:0]           req_rdata;
    logic [NUM_REQ-1:0]     req_rvalid;
    logic [NUM_REQ-1:0]     req_rready;

    logic [31:0]            mem_cmd_addr;
    logic [2:0]             mem_cmd_type;
    logic                   mem_cmd_valid;
    logic                   mem_cmd_ready;
    logic [127:0]           mem_wr_data;
    logic [15:0]            mem_wr_mask;
    logic                   mem_wr_valid;
    logic                   mem_wr_ready;
    logic [127:0]           mem_rd_data;
    logic                   mem_rd_valid;
    logic                   mem_rd_ready;

    modport slave (
        input  req_addr, req_type, req_valid, req_wdata, req_wmask, req_wvalid, req_rready,
        input  mem_cmd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid,
        output req_ready, req_wready, req_rdata, req_rvalid,
        output mem_cmd_addr, mem_cmd_type, mem_cmd_valid, mem_wr_data, mem_wr_mask,
        output mem_wr_valid, mem_rd_ready
    );

    modport master (
        output req_addr, req_type, req_valid, req_wdata, req_wmask, req_wvalid, req_rready,
        output mem_cmd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid,
        input  req_ready, req_wready, req_rdata, req_rvalid,
        input  mem_cmd_addr, mem_cmd_type, mem_cmd_valid, mem_wr_data, mem_wr_mask,
        input  mem_wr_valid, mem_rd_ready
    );
endinterface

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; push and pop may coincide when full.
module mem_arb_id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory-controller host port among NUM_REQ requesters.
// Build option MEM_ARB_QOS_EN gives requester 0 strict priority over the round-robin group.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned RD_OUTSTD = 8
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    mem_req_arbiter_if.slave bus,
    output logic             arb_busy,
    output logic             rd_orphan_err
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              orphan_q, orphan_d;

    logic [ADDR_W-1:0] addr_a  [NUM_REQ];
    logic [TYPE_W-1:0] type_a  [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];
    logic [MASK_W-1:0] wmask_a [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic              found;
    logic [IDX_W-1:0]  pick, cand, gnt_nxt;
    int unsigned       idx;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IDX_W-1:0]  fifo_head;

    logic [NUM_REQ-1:0] req_ready, req_wready, req_rvalid;
    logic              mem_cmd_valid, mem_wr_valid, mem_rd_ready;

    // Unpack per-requester slices and find the winner from the RR pointer
    always_comb begin
        elig  = '0;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_a[i]  = bus.req_addr[ADDR_W*i +: ADDR_W];
            type_a[i]  = bus.req_type[TYPE_W*i +: TYPE_W];
            wdata_a[i] = bus.req_wdata[DATA_W*i +: DATA_W];
            wmask_a[i] = bus.req_wmask[MASK_W*i +: MASK_W];
            elig[i]    = bus.req_valid[i] && !(is_read(type_a[i]) && fifo_full);
        end
`ifdef MEM_ARB_QOS_EN
        if (elig[0]) begin
            found = 1'b1;
        end
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx  = (32'(ptr_q) + k) % NUM_REQ;
            cand = IDX_W'(idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign gnt_nxt = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);

    // Command FSM: grant in IDLE, present in CMD, pass one write beat in WDATA
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        gnt_d         = gnt_q;
        ptr_d         = ptr_q;
        fifo_push     = 1'b0;
        req_ready     = '0;
        req_wready    = '0;
        mem_cmd_valid = 1'b0;
        mem_wr_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[pick] = 1'b1;
                    cmd_d           = '{addr: addr_a[pick], typ: type_a[pick]};
                    gnt_d           = pick;
                    state_d         = CMD;
                end
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                if (bus.mem_cmd_ready) begin
`ifdef MEM_ARB_QOS_EN
                    if (gnt_q != '0) begin
                        ptr_d = gnt_nxt;
                    end
`else
                    ptr_d = gnt_nxt;
`endif
                    fifo_push = is_read(cmd_q.typ);
                    state_d   = (cmd_q.typ == CMD_WRITE) ? WDATA : IDLE;
                end
            end
            WDATA: begin
                mem_wr_valid      = bus.req_wvalid[gnt_q];
                req_wready[gnt_q] = bus.mem_wr_ready;
                if (bus.req_wvalid[gnt_q] && bus.mem_wr_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The IDLE grant is combinational; keep it quiet while reset is held
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    // Read return follows the oldest outstanding ID; orphan data is drained and flagged
    always_comb begin
        req_rvalid   = '0;
        mem_rd_ready = 1'b1;
        if (!fifo_empty) begin
            req_rvalid[fifo_head] = bus.mem_rd_valid;
            mem_rd_ready          = bus.req_rready[fifo_head];
        end
        fifo_pop = bus.mem_rd_valid && mem_rd_ready && !fifo_empty;
        orphan_d = orphan_q || (bus.mem_rd_valid && fifo_empty);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            gnt_q    <= '0;
            ptr_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            orphan_q <= orphan_d;
        end
    end

    mem_arb_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (RD_OUTSTD)
    ) u_id_fifo (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (gnt_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.req_ready     = req_ready;
    assign bus.req_wready    = req_wready;
    assign bus.req_rvalid    = req_rvalid;
    assign bus.req_rdata     = bus.mem_rd_data;
    assign bus.mem_cmd_addr  = cmd_q.addr;
    assign bus.mem_cmd_type  = cmd_q.typ;
    assign bus.mem_cmd_valid = mem_cmd_valid;
    assign bus.mem_wr_data   = wdata_a[gnt_q];
    assign bus.mem_wr_mask   = wmask_a[gnt_q];
    assign bus.mem_wr_valid  = mem_wr_valid;
    assign bus.mem_rd_ready  = mem_rd_ready;
    assign arb_busy          = (state_q != IDLE) || !fifo_empty;
    assign rd_orphan_err     = orphan_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: vector table for arbitration/read return plus corner sequences.
module tb_mem_req_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic arb_busy, rd_orphan_err;
    int   checks = 0;
    int   errors = 0;

    mem_req_arbiter_if #(.NUM_REQ(N)) bus ();

    mem_req_arbiter #(
        .NUM_REQ   (N),
        .RD_OUTSTD (8)
    ) dut (
        .sys_clk       (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .arb_busy      (arb_busy),
        .rd_orphan_err (rd_orphan_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic        rd_vld;
        logic [3:0]  e_ready;
        logic        e_cvld;
        logic [31:0] e_addr;
        logic [3:0]  e_rvld;
        logic        e_rd_rdy;
        logic        e_busy;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [3:0] valid, input logic rd_vld, input logic [3:0] e_ready,
                                input logic e_cvld, input logic [31:0] e_addr, input logic [3:0] e_rvld,
                                input logic e_rd_rdy, input logic e_busy);
        vec_t v;
        v.valid = valid;   v.rd_vld = rd_vld; v.e_ready = e_ready; v.e_cvld = e_cvld;
        v.e_addr = e_addr; v.e_rvld = e_rvld; v.e_rd_rdy = e_rd_rdy; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] t);
        bus.req_valid[i]       = v;
        bus.req_type[3*i +: 3] = t;
    endtask

    task automatic issue(input int i, input logic [2:0] t);
        set_req(i, 1'b1, t);
        #1;
        chk("issue_ready", 128'(bus.req_ready), 128'(4'b0001 << i));
        tick();
        set_req(i, 1'b0, t);
        #1;
        chk("issue_cmd_valid", 128'(bus.mem_cmd_valid), 128'(1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d0, d1;
        logic [3:0]   exp_q;
        d0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d1 = ~d0;

        rst_n             = 1'b0;
        bus.req_addr      = '0;
        bus.req_type      = '0;
        bus.req_valid     = '0;
        bus.req_wdata     = '0;
        bus.req_wmask     = '0;
        bus.req_wvalid    = '0;
        bus.req_rready    = 4'b1111;
        bus.mem_cmd_ready = 1'b1;
        bus.mem_wr_ready  = 1'b1;
        bus.mem_rd_data   = '0;
        bus.mem_rd_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[32*i +: 32] = 32'h1000 + 32'(16 * i);
        end

        // Table: four simultaneous reads granted 0..3, then returned in order
        vecs[0]  = mk(4'b1111, 0, 4'b0001, 0, 32'h0,    4'b0000, 1, 0);
        vecs[1]  = mk(4'b1111, 0, 4'b0000, 1, 32'h1000, 4'b0000, 1, 1);
        vecs[2]  = mk(4'b1111, 0, 4'b0010, 0, 32'h0,    4'b0000, 1, 1);
        vecs[3]  = mk(4'b1111, 0, 4'b0000, 1, 32'h1010, 4'b0000, 1, 1);
        vecs[4]  = mk(4'b1111, 0, 4'b0100, 0, 32'h0,    4'b0000, 1, 1);
        vecs[5]  = mk(4'b1111, 0, 4'b0000, 1, 32'h1020, 4'b0000, 1, 1);
        vecs[6]  = mk(4'b1111, 0, 4'b1000, 0, 32'h0,    4'b0000, 1, 1);
        vecs[7]  = mk(4'b1111, 0, 4'b0000, 1, 32'h1030, 4'b0000, 1, 1);
        vecs[8]  = mk(4'b0000, 0, 4'b0000, 0, 32'h0,    4'b0000, 1, 1);
        vecs[9]  = mk(4'b0000, 1, 4'b0000, 0, 32'h0,    4'b0001, 1, 1);
        vecs[10] = mk(4'b0000, 1, 4'b0000, 0, 32'h0,    4'b0010, 1, 1);
        vecs[11] = mk(4'b0000, 1, 4'b0000, 0, 32'h0,    4'b0100, 1, 1);
        vecs[12] = mk(4'b0000, 1, 4'b0000, 0, 32'h0,    4'b1000, 1, 1);
        vecs[13] = mk(4'b0000, 0, 4'b0000, 0, 32'h0,    4'b0000, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_valid", 128'(bus.mem_cmd_valid), 128'(0));
        chk("rst_cmd_addr", 128'(bus.mem_cmd_addr), 128'(0));
        chk("rst_busy", 128'(arb_busy), 128'(0));
        chk("rst_orphan", 128'(rd_orphan_err), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int r = 0; r < 14; r++) begin
            bus.req_valid = vecs[r].valid;
            for (int i = 0; i < 4; i++) bus.req_type[3*i +: 3] = CMD_READ;
            bus.mem_rd_valid = vecs[r].rd_vld;
            #1;
            chk($sformatf("v%0d_ready", r), 128'(bus.req_ready), 128'(vecs[r].e_ready));
            chk($sformatf("v%0d_cmd_valid", r), 128'(bus.mem_cmd_valid), 128'(vecs[r].e_cvld));
            if (vecs[r].e_cvld)
                chk($sformatf("v%0d_cmd_addr", r), 128'(bus.mem_cmd_addr), 128'(vecs[r].e_addr));
            chk($sformatf("v%0d_rvalid", r), 128'(bus.req_rvalid), 128'(vecs[r].e_rvld));
            chk($sformatf("v%0d_rd_ready", r), 128'(bus.mem_rd_ready), 128'(vecs[r].e_rd_rdy));
            chk($sformatf("v%0d_busy", r), 128'(arb_busy), 128'(vecs[r].e_busy));
            tick();
        end
        bus.req_valid = '0;

        // Write from req2 with its beat arriving three cycles late
        bus.req_addr[64 +: 32]    = 32'h100;
        bus.req_wdata[256 +: 128] = {16{8'hA5}};
        bus.req_wmask[32 +: 16]   = 16'hFFFF;
        set_req(2, 1'b1, CMD_WRITE);
        #1;
        chk("wr_grant", 128'(bus.req_ready), 128'(4'b0100));
        tick();
        set_req(2, 1'b0, CMD_WRITE);
        #1;
        chk("wr_cmd_valid", 128'(bus.mem_cmd_valid), 128'(1));
        chk("wr_cmd_addr", 128'(bus.mem_cmd_addr), 128'(32'h100));
        chk("wr_cmd_type", 128'(bus.mem_cmd_type), 128'(CMD_WRITE));
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wr_wait_valid", 128'(bus.mem_wr_valid), 128'(0));
            chk("wr_wait_busy", 128'(arb_busy), 128'(1));
            tick();
        end
        bus.req_wvalid[2] = 1'b1;
        #1;
        chk("wr_beat_valid", 128'(bus.mem_wr_valid), 128'(1));
        chk("wr_beat_data", bus.mem_wr_data, {16{8'hA5}});
        chk("wr_beat_mask", 128'(bus.mem_wr_mask), 128'(16'hFFFF));
        chk("wr_beat_wready", 128'(bus.req_wready), 128'(4'b0100));
        tick();
        #1;
        chk("wr_single_beat", 128'(bus.mem_wr_valid), 128'(0));
        chk("wr_single_wready", 128'(bus.req_wready), 128'(0));
        bus.req_wvalid[2] = 1'b0;
        tick();

        // Reads from req1 then req3; data routed in issue order with a stall on req1
        set_req(1, 1'b1, CMD_READ);
        #1;
        chk("rd1_grant", 128'(bus.req_ready), 128'(4'b0010));
        tick();
        set_req(1, 1'b0, CMD_READ);
        tick();
        set_req(3, 1'b1, CMD_READ);
        #1;
        chk("rd3_grant", 128'(bus.req_ready), 128'(4'b1000));
        tick();
        set_req(3, 1'b0, CMD_READ);
        tick();
        bus.req_rready   = 4'b1101;
        bus.mem_rd_data  = d0;
        bus.mem_rd_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_rvalid", 128'(bus.req_rvalid), 128'(4'b0010));
            chk("stall_rd_ready", 128'(bus.mem_rd_ready), 128'(0));
            chk("stall_rdata", bus.req_rdata, d0);
            tick();
        end
        bus.req_rready = 4'b1111;
        #1;
        chk("d0_rvalid", 128'(bus.req_rvalid), 128'(4'b0010));
        chk("d0_rd_ready", 128'(bus.mem_rd_ready), 128'(1));
        tick();
        bus.mem_rd_data = d1;
        #1;
        chk("d1_rvalid", 128'(bus.req_rvalid), 128'(4'b1000));
        chk("d1_rdata", bus.req_rdata, d1);
        tick();
        bus.mem_rd_valid = 1'b0;
        #1;
        chk("rd_drained_busy", 128'(arb_busy), 128'(0));
        tick();

        // Fill the ID FIFO; a read is blocked while a write still gets through
        for (int k = 0; k < 8; k++) issue(0, CMD_READ);
        set_req(1, 1'b1, CMD_READ);
        set_req(2, 1'b1, CMD_WRITE);
        #1;
        chk("full_write_grant", 128'(bus.req_ready), 128'(4'b0100));
        tick();
        set_req(2, 1'b0, CMD_WRITE);
        #1;
        chk("full_write_type", 128'(bus.mem_cmd_type), 128'(CMD_WRITE));
        tick();
        bus.req_wvalid[2] = 1'b1;
        #1;
        chk("full_write_wready", 128'(bus.req_wready), 128'(4'b0100));
        tick();
        bus.req_wvalid[2] = 1'b0;
        #1;
        chk("full_read_blocked", 128'(bus.req_ready), 128'(0));
        bus.mem_rd_valid = 1'b1;
        #1;
        chk("full_pop_rvalid", 128'(bus.req_rvalid), 128'(4'b0001));
        chk("full_still_blocked", 128'(bus.req_ready), 128'(0));
        tick();
        bus.mem_rd_valid = 1'b0;
        #1;
        chk("after_pop_grant", 128'(bus.req_ready), 128'(4'b0010));
        tick();
        set_req(1, 1'b0, CMD_READ);
        tick();
        for (int k = 0; k < 8; k++) begin
            bus.mem_rd_valid = 1'b1;
            exp_q = (k < 7) ? 4'b0001 : 4'b0010;
            #1;
            chk($sformatf("drain%0d_rvalid", k), 128'(bus.req_rvalid), 128'(exp_q));
            tick();
        end
        bus.mem_rd_valid = 1'b0;
        #1;
        chk("drain_busy", 128'(arb_busy), 128'(0));
        tick();

        // Read data with nothing outstanding is drained and flagged sticky
        bus.mem_rd_valid = 1'b1;
        #1;
        chk("orphan_rd_ready", 128'(bus.mem_rd_ready), 128'(1));
        chk("orphan_rvalid", 128'(bus.req_rvalid), 128'(0));
        chk("orphan_pre", 128'(rd_orphan_err), 128'(0));
        tick();
        bus.mem_rd_valid = 1'b0;
        #1;
        chk("orphan_set", 128'(rd_orphan_err), 128'(1));
        tick();
        tick();
        chk("orphan_held", 128'(rd_orphan_err), 128'(1));

        // Asynchronous reset while a command is waiting in CMD
        bus.mem_cmd_ready = 1'b0;
        set_req(0, 1'b1, CMD_READ);
        #1;
        chk("rstcmd_grant", 128'(bus.req_ready), 128'(4'b0001));
        tick();
        set_req(0, 1'b0, CMD_READ);
        #1;
        chk("rstcmd_cmd_valid", 128'(bus.mem_cmd_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async_cmd_valid", 128'(bus.mem_cmd_valid), 128'(0));
        chk("async_cmd_addr", 128'(bus.mem_cmd_addr), 128'(0));
        chk("async_cmd_type", 128'(bus.mem_cmd_type), 128'(0));
        chk("async_busy", 128'(arb_busy), 128'(0));
        chk("async_orphan", 128'(rd_orphan_err), 128'(0));
        chk("async_ready", 128'(bus.req_ready), 128'(0));
        chk("async_wr_valid", 128'(bus.mem_wr_valid), 128'(0));
        tick();
        rst_n = 1'b1;
        bus.mem_cmd_ready = 1'b1;
        tick();

        // Req0 and req1 both holding command-only requests
        set_req(0, 1'b1, 3'b011);
        set_req(1, 1'b1, 3'b011);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_QOS_EN
            exp_q = 4'b0001;
`else
            exp_q = ((k % 2) == 0) ? 4'b0001 : 4'b0010;
`endif
            #1;
            chk($sformatf("share%0d_grant", k), 128'(bus.req_ready), 128'(exp_q));
            tick();
            tick();
        end
        bus.req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
